// File: rtl/mb_arbiter.sv
// mb_arbiter: round-robin arbiter sharing one synchronous memory port
// between NREQ requesters, with bounded locked bursts and read-data
// steering back to the requester that issued each read.
//
// Handshake: a requester holds req[i] (with its we/bmsk/addr/wdata) until
// it sees gnt[i]; the access is consumed in the same cycle gnt[i] is high.
// Read data comes back as a one-cycle rvalid[i] pulse RD_LAT cycles later.
module mb_arbiter #(
    parameter int NREQ      = 3,
    parameter int DSZ       = 16,
    parameter int ASZ       = 17,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [NREQ-1:0]     we,
    input  logic [4*NREQ-1:0]   bmsk,
    input  logic [ASZ*NREQ-1:0] addr,
    input  logic [DSZ*NREQ-1:0] wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [DSZ-1:0]      rdata,
    output logic                mem_we,
    output logic [3:0]          mem_bmsk,
    output logic [ASZ-1:0]      mem_ai,
    output logic [DSZ-1:0]      mem_vi,
    input  logic [DSZ-1:0]      mem_vo,
    output logic                dbg_state
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE_ARB = 1'b0, LOCKED = 1'b1} arb_state_e;

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [7:0]          bcnt_q, bcnt_d;
    // Set for one cycle after a burst is cut at MAX_BURST; owner_q then
    // names the requester that must step aside if anyone else is waiting.
    logic                bar_q, bar_d;

    logic [RD_LAT-1:0]   rd_vld_q;
    logic [IW-1:0]       rd_idx_q [RD_LAT];

    logic [NREQ-1:0]     owner_mask;
    logic [NREQ-1:0]     elig;
    logic [IW-1:0]       cand;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;
    logic                rd_push;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        return i + 1'b1;
    endfunction

    assign dbg_state  = state_q;
    assign owner_mask = NREQ'(1) << owner_q;

    // Grant selection: owner only while locked, otherwise round-robin from rr_q.
    always_comb begin
        elig    = req;
        cand    = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (bar_q && ((req & ~owner_mask) != '0)) begin
            elig = req & ~owner_mask;
        end
        if (state_q == LOCKED) begin
            gnt_idx = owner_q;
            gnt_any = req[owner_q];
        end else begin
            // Walk downwards so the candidate closest to rr_q wins last.
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = IW'((int'(rr_q) + k) % NREQ);
                if (elig[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        // Nothing reaches the memory while the block is held in reset.
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
        gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end

    // Memory port mux: granted requester's fields, all zero when idle.
    always_comb begin
        mem_we   = 1'b0;
        mem_bmsk = '0;
        mem_ai   = '0;
        mem_vi   = '0;
        if (gnt_any) begin
            mem_we   = we[gnt_idx];
            mem_bmsk = bmsk[4*gnt_idx +: 4];
            mem_ai   = addr[ASZ*gnt_idx +: ASZ];
            mem_vi   = wdata[DSZ*gnt_idx +: DSZ];
        end
    end

    // Arbiter next state: lock entry/exit, burst counting and rr update.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        bcnt_d  = bcnt_q;
        bar_d   = 1'b0;
        case (state_q)
            IDLE_ARB: begin
                if (gnt_any) begin
                    if (lock[gnt_idx]) begin
                        state_d = LOCKED;
                        owner_d = gnt_idx;
                        bcnt_d  = 8'd1;
                    end else begin
                        rr_d = next_idx(gnt_idx);
                    end
                end
            end
            LOCKED: begin
                if (!gnt_any) begin
                    state_d = IDLE_ARB;
                    rr_d    = next_idx(owner_q);
                    bcnt_d  = '0;
                end else if (bcnt_q + 8'd1 == 8'(MAX_BURST)) begin
                    state_d = IDLE_ARB;
                    rr_d    = next_idx(owner_q);
                    bcnt_d  = '0;
                    bar_d   = 1'b1;
                end else if (!lock[owner_q]) begin
                    state_d = IDLE_ARB;
                    rr_d    = next_idx(owner_q);
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE_ARB;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_ARB;
            rr_q    <= '0;
            owner_q <= '0;
            bcnt_q  <= '0;
            bar_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
            bar_q   <= bar_d;
        end
    end

    assign rd_push = gnt_any & ~we[gnt_idx];

    // Read-return pipeline tracking which requester each memory read belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) rd_idx_q[k] <= '0;
        end else begin
            rd_vld_q[0] <= rd_push;
            rd_idx_q[0] <= gnt_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                rd_idx_q[k] <= rd_idx_q[k-1];
            end
        end
    end

    assign rvalid = rd_vld_q[RD_LAT-1] ? (NREQ'(1) << rd_idx_q[RD_LAT-1]) : '0;
    assign rdata  = rd_vld_q[RD_LAT-1] ? mem_vo : '0;

endmodule

// File: tb/tb_mb_arbiter.sv
// Bench for mb_arbiter: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural arbitration/memory model.
module tb_mb_arbiter;
    localparam int NREQ      = 3;
    localparam int DSZ       = 16;
    localparam int ASZ       = 17;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;
    localparam int EW        = 32 + 8 + DSZ;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]     req, lock, we;
    logic [4*NREQ-1:0]   bmsk;
    logic [ASZ*NREQ-1:0] addr;
    logic [DSZ*NREQ-1:0] wdata;
    logic [NREQ-1:0]     gnt, rvalid;
    logic [DSZ-1:0]      rdata;
    logic                mem_we;
    logic [3:0]          mem_bmsk;
    logic [ASZ-1:0]      mem_ai;
    logic [DSZ-1:0]      mem_vi, mem_vo;
    logic                dbg_state;

    mb_arbiter #(.NREQ(NREQ), .DSZ(DSZ), .ASZ(ASZ), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .bmsk(bmsk),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_we(mem_we), .mem_bmsk(mem_bmsk), .mem_ai(mem_ai), .mem_vi(mem_vi),
        .mem_vo(mem_vo), .dbg_state(dbg_state)
    );

    // ---------------- memory block (environment) ----------------
    logic [DSZ-1:0] bmem [0:255];
    logic [DSZ-1:0] rpipe [0:RD_LAT-1];
    logic           preload;
    logic [7:0]     pl_addr;
    logic [DSZ-1:0] pl_data;

    always @(posedge clk) begin
        if (preload) bmem[pl_addr] <= pl_data;
        else if (mem_we) bmem[mem_ai[7:0]] <= mem_vi;
        rpipe[0] <= bmem[mem_ai[7:0]];
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_vo = rpipe[RD_LAT-1];

    // ---------------- reference model ----------------
    logic [DSZ-1:0] shadow [0:255];
    logic [EW-1:0]  exp_q[$];
    int m_rr, m_owner, m_cnt, m_bar, cyc;
    bit m_locked;

    logic [NREQ-1:0] d_req, d_lock, d_we;
    logic [3:0]      d_bmsk [NREQ];
    logic [ASZ-1:0]  d_addr [NREQ];
    logic [DSZ-1:0]  d_wdata [NREQ];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // Winner for the current inputs, -1 when nobody is granted.
    function automatic int pick();
        logic [NREQ-1:0] el;
        int idx;
        if (m_locked) return d_req[m_owner] ? m_owner : -1;
        el = d_req;
        if (m_bar >= 0) begin
            for (int i = 0; i < NREQ; i++)
                if (i != m_bar && d_req[i]) el[m_bar] = 1'b0;
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (el[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_cnt = 0; m_bar = -1; m_locked = 0;
        exp_q.delete();
    endtask

    task automatic model_advance(input int w);
        int bar_n;
        bar_n = -1;
        if (w >= 0) begin
            if (d_we[w]) shadow[d_addr[w][7:0]] = d_wdata[w];
            else exp_q.push_back({32'(cyc + RD_LAT), 8'(w), shadow[d_addr[w][7:0]]});
        end
        if (m_locked) begin
            if (w < 0) begin
                m_locked = 0; m_rr = (m_owner + 1) % NREQ;
            end else begin
                m_cnt++;
                if (m_cnt == MAX_BURST) begin
                    m_locked = 0; m_rr = (m_owner + 1) % NREQ; bar_n = m_owner;
                end else if (!d_lock[w]) begin
                    m_locked = 0; m_rr = (m_owner + 1) % NREQ;
                end
            end
        end else if (w >= 0) begin
            if (d_lock[w]) begin
                m_locked = 1; m_owner = w; m_cnt = 1;
            end else begin
                m_rr = (w + 1) % NREQ;
            end
        end
        m_bar = bar_n;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pack_inputs();
        req = d_req; lock = d_lock; we = d_we;
        for (int i = 0; i < NREQ; i++) begin
            bmsk[4*i +: 4]     = d_bmsk[i];
            addr[ASZ*i +: ASZ] = d_addr[i];
            wdata[DSZ*i +: DSZ] = d_wdata[i];
        end
    endtask

    task automatic clear_inputs();
        d_req = '0; d_lock = '0; d_we = '0;
        for (int i = 0; i < NREQ; i++) begin
            d_bmsk[i] = 4'($urandom_range(0, 15));
            d_addr[i] = ASZ'($urandom_range(0, 31));
            d_wdata[i] = DSZ'($urandom);
        end
    endtask

    task automatic rand_inputs();
        clear_inputs();
        for (int i = 0; i < NREQ; i++) begin
            d_req[i]  = ($urandom_range(0, 9) < 7);
            d_lock[i] = ($urandom_range(0, 9) < 5);
            d_we[i]   = ($urandom_range(0, 9) < 4);
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance model on the edge.
    task automatic step();
        int w;
        logic [EW-1:0] e;
        logic [NREQ-1:0] x_gnt, x_rv;
        logic [DSZ-1:0] x_rd;
        pack_inputs();
        #3;
        w = pick();
        x_gnt = (w >= 0) ? (NREQ'(1) << w) : '0;
        x_rv = '0;
        x_rd = '0;
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
            e = exp_q.pop_front();
            x_rv = NREQ'(1) << e[DSZ +: 8];
            x_rd = e[DSZ-1:0];
        end
        check("gnt", 32'(gnt), 32'(x_gnt));
        check("mem_we", 32'(mem_we), (w >= 0) ? 32'(d_we[w]) : 32'd0);
        check("mem_bmsk", 32'(mem_bmsk), (w >= 0) ? 32'(d_bmsk[w]) : 32'd0);
        check("mem_ai", 32'(mem_ai), (w >= 0) ? 32'(d_addr[w]) : 32'd0);
        check("mem_vi", 32'(mem_vi), (w >= 0) ? 32'(d_wdata[w]) : 32'd0);
        check("rvalid", 32'(rvalid), 32'(x_rv));
        check("rdata", 32'(rdata), 32'(x_rd));
        @(posedge clk);
        model_advance(w);
        cyc++;
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        clear_inputs();
        pack_inputs();
        model_reset();
        for (int i = 0; i < n; i++) begin
            #3;
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_rvalid", 32'(rvalid), 32'd0);
            check("rst_rdata", 32'(rdata), 32'd0);
            check("rst_state", 32'(dbg_state), 32'd0);
            @(posedge clk);
            cyc++;
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clear_inputs();
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc = 0;
        rst_n = 1'b0;
        preload = 1'b1;
        pl_addr = '0;
        pl_data = '0;
        clear_inputs();
        pack_inputs();
        for (int i = 0; i < 256; i++) begin
            pl_addr = 8'(i);
            pl_data = (i == 'h40) ? 16'hBEEF : DSZ'($urandom);
            shadow[i] = pl_data;
            @(posedge clk);
            #1;
        end
        preload = 1'b0;

        // Reset, then a single read by requester 1 from 0x00040.
        apply_reset(3);
        clear_inputs();
        d_req = 3'b010; d_addr[1] = 17'h00040;
        step();
        idle(3);

        // Round-robin fairness with all three requesting.
        apply_reset(2);
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            d_req = 3'b111;
            step();
        end
        idle(3);

        // Locked burst capped at MAX_BURST with requester 2 waiting.
        apply_reset(2);
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            d_req = 3'b101; d_lock = 3'b001;
            step();
        end
        idle(3);

        // Early lock release.
        apply_reset(2);
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            d_req = 3'b010; d_lock = 3'b010;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            d_req = 3'b110;
            step();
        end
        idle(3);

        // Write then two back-to-back reads of the same word.
        apply_reset(2);
        clear_inputs();
        d_req = 3'b001; d_we = 3'b001; d_addr[0] = 17'h10; d_wdata[0] = 16'h1234;
        step();
        clear_inputs();
        d_req = 3'b100; d_addr[2] = 17'h10;
        step();
        clear_inputs();
        d_req = 3'b010; d_addr[1] = 17'h10;
        step();
        idle(4);

        // Reset pulled the cycle after a read grant drops the read.
        clear_inputs();
        d_req = 3'b001;
        step();
        apply_reset(2);
        idle(4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) apply_reset($urandom_range(1, 2));
            rand_inputs();
            step();
        end
        idle(RD_LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
